// File: rtl/konwersja_out_buf.sv
// Registered two-entry skid buffer for konwersja results, with a saturating error counter and
// a sticky error flag. Ready toward upstream comes straight from a flop.
module konwersja_out_buf #(
    parameter int unsigned BITS      = 32,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [BITS-1:0]      i_result,
    input  logic                 i_error,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [BITS-1:0]      o_result,
    output logic                 o_error,
    input  logic                 i_clr_err,
    output logic [ERR_CNT_W-1:0] o_err_count,
    output logic                 o_err_sticky
);

    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [BITS:0]        main_q, main_d;
    logic [BITS:0]        skid_q, skid_d;
    logic                 ready_q, ready_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;

    logic          push;
    logic          pop;
    logic          inc;
    logic [BITS:0] entry;

    assign entry = {i_error, i_result};
    assign push  = i_valid & ready_q;
    assign pop   = (state_q != StEmpty) & i_ready;
    assign inc   = push & i_error;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            StEmpty: begin
                if (push) begin
                    main_d  = entry;
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && pop) begin
                    main_d = entry;
                end else if (push) begin
                    skid_d  = entry;
                    state_d = StFull;
                end else if (pop) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    main_d  = skid_q;
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Ready is decided one cycle ahead from the next state, so it never sees i_ready directly.
    assign ready_d = (state_d != StFull);

    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        if (i_clr_err) begin
            cnt_d    = ERR_CNT_W'(inc);
            sticky_d = inc;
        end else begin
            if (inc && (cnt_q != {ERR_CNT_W{1'b1}})) begin
                cnt_d = cnt_q + 1'b1;
            end
            sticky_d = sticky_q | inc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StEmpty;
            main_q   <= '0;
            skid_q   <= '0;
            ready_q  <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            ready_q  <= ready_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_valid      = (state_q != StEmpty);
    assign o_result     = main_q[BITS-1:0];
    assign o_error      = main_q[BITS];
    assign o_err_count  = cnt_q;
    assign o_err_sticky = sticky_q;

endmodule

// File: tb/tb_konwersja_out_buf.sv
// Directed bench for konwersja_out_buf; a second instance with a 2-bit counter checks saturation.
module tb_konwersja_out_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_result;
    logic        in_error;
    logic        in_ready;
    logic        clr_err;

    logic        out_ready, out_valid, out_error, out_sticky;
    logic [31:0] out_result;
    logic [7:0]  out_count;

    logic        out2_ready, out2_valid, out2_error, out2_sticky;
    logic [31:0] out2_result;
    logic [1:0]  out2_count;

    int n_checks = 0;
    int n_fails  = 0;

    logic [31:0] words[16];

    always #5 clk = ~clk;

    konwersja_out_buf #(.BITS(32), .ERR_CNT_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out_ready),
        .i_result(in_result), .i_error(in_error), .o_valid(out_valid), .i_ready(in_ready),
        .o_result(out_result), .o_error(out_error), .i_clr_err(clr_err),
        .o_err_count(out_count), .o_err_sticky(out_sticky)
    );

    konwersja_out_buf #(.BITS(32), .ERR_CNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(in_valid), .o_ready(out2_ready),
        .i_result(in_result), .i_error(in_error), .o_valid(out2_valid), .i_ready(in_ready),
        .o_result(out2_result), .o_error(out2_error), .i_clr_err(clr_err),
        .o_err_count(out2_count), .o_err_sticky(out2_sticky)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_result = '0;
        in_error  = 1'b0;
        in_ready  = 1'b0;
        clr_err   = 1'b0;

        // 1) reset state, single pass-through
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_result", 64'(out_result), 64'd0);
        check("rst_error", 64'(out_error), 64'd0);
        check("rst_count", 64'(out_count), 64'd0);
        check("rst_sticky", 64'(out_sticky), 64'd0);
        check("rst_ready", 64'(out_ready), 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 64'(out_ready), 64'd1);
        check("post_rst_valid", 64'(out_valid), 64'd0);
        in_valid  = 1'b1;
        in_result = 32'h0000_0005;
        in_ready  = 1'b1;
        tick();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_result", 64'(out_result), 64'h5);
        check("t1_error", 64'(out_error), 64'd0);
        in_valid = 1'b0;
        tick();
        check("t1_valid_after", 64'(out_valid), 64'd0);
        check("t1_ready_after", 64'(out_ready), 64'd1);
        check("t1_hold_result", 64'(out_result), 64'h5);

        // 2) fill to FULL with downstream stalled, then drain
        in_ready  = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'h1;
        tick();
        check("t2_one_valid", 64'(out_valid), 64'd1);
        check("t2_one_ready", 64'(out_ready), 64'd1);
        check("t2_one_result", 64'(out_result), 64'h1);
        in_result = 32'h2;
        tick();
        check("t2_full_ready", 64'(out_ready), 64'd0);
        check("t2_full_result", 64'(out_result), 64'h1);
        in_result = 32'h3;
        tick();
        check("t2_held_ready", 64'(out_ready), 64'd0);
        check("t2_held_result", 64'(out_result), 64'h1);
        in_valid = 1'b0;
        in_ready = 1'b1;
        tick();
        check("t2_pop1_result", 64'(out_result), 64'h2);
        check("t2_pop1_valid", 64'(out_valid), 64'd1);
        check("t2_pop1_ready", 64'(out_ready), 64'd1);
        tick();
        check("t2_pop2_valid", 64'(out_valid), 64'd0);
        check("t2_count", 64'(out_count), 64'd0);

        // 3) streaming at full rate
        foreach (words[i]) words[i] = $urandom;
        in_valid = 1'b1;
        in_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_result = words[i];
            tick();
            check("t3_result", 64'(out_result), 64'(words[i]));
            check("t3_valid", 64'(out_valid), 64'd1);
            check("t3_ready", 64'(out_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("t3_drained", 64'(out_valid), 64'd0);

        // 4) saturating error count (2-bit instance) vs 8-bit instance
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        in_valid  = 1'b1;
        in_error  = 1'b1;
        in_result = 32'h8000_0000;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("t4_count2", 64'(out2_count), (i > 3) ? 64'd3 : 64'(i));
            check("t4_count8", 64'(out_count), 64'(i));
            check("t4_sticky", 64'(out2_sticky), 64'd1);
            check("t4_error", 64'(out2_error), 64'd1);
            check("t4_result", 64'(out2_result), 64'h8000_0000);
        end
        in_valid = 1'b0;
        tick();

        // 5) clear coinciding with errored push, then plain clear
        clr_err  = 1'b1;
        in_valid = 1'b1;
        tick();
        check("t5_clr_push_cnt", 64'(out_count), 64'd1);
        check("t5_clr_push_cnt2", 64'(out2_count), 64'd1);
        check("t5_clr_push_sticky", 64'(out_sticky), 64'd1);
        in_valid = 1'b0;
        tick();
        check("t5_clr_cnt", 64'(out_count), 64'd0);
        check("t5_clr_sticky", 64'(out_sticky), 64'd0);
        clr_err = 1'b0;

        // errored offer while not ready is ignored
        in_ready  = 1'b0;
        in_valid  = 1'b1;
        in_result = 32'hA;
        tick();
        in_result = 32'hB;
        tick();
        in_result = 32'hC;
        tick();
        check("t5_ignored_cnt", 64'(out_count), 64'd2);
        check("t5_full_ready", 64'(out_ready), 64'd0);

        // 6) reset while FULL
        rst = 1'b1;
        tick();
        check("t6_valid", 64'(out_valid), 64'd0);
        check("t6_result", 64'(out_result), 64'd0);
        check("t6_error", 64'(out_error), 64'd0);
        check("t6_count", 64'(out_count), 64'd0);
        check("t6_sticky", 64'(out_sticky), 64'd0);
        check("t6_ready", 64'(out_ready), 64'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check("t6_ready_after", 64'(out_ready), 64'd1);
        check("t6_valid_after", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
